latch_write_ctrl: RTL and testbench
===================================

# latch_write_ctrl

Write sequencer sitting directly upstream of the enable/reset D-latch bank. It accepts a data word over a valid/ready handshake and drives the latch `d` and `en` inputs with guaranteed setup, enable-pulse and hold windows, all counted in clock cycles. Each write is completed before the next word is accepted, so the latch never sees `d` change while `en` is high.

## Interface
Parameters:
- `WIDTH`, 8: data word width.
- `SETUP_CYC`, 2: cycles `d` is stable before `en` rises. Must be ≥1.
- `PULSE_CYC`, 3: cycles `en` is high. Must be ≥1.
- `HOLD_CYC`, 1: cycles `d` is held after `en` falls. Must be ≥1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  word to be written.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word (high only in IDLE).
- `d`  out  WIDTH  latch data input.
- `en`  out  1  latch enable.
- `busy`  out  1  write in progress (not IDLE).
- `done`  out  1  one-cycle pulse when a write completes.
- `q_rb`  in  WIDTH  latch `q` readback. Present only with `LATCH_WR_READBACK_EN`.
- `wr_err`  out  1  readback mismatch pulse. Present only with `LATCH_WR_READBACK_EN`.

## Operation
- States: IDLE → SETUP → PULSE → HOLD → IDLE.
- One loadable down-counter times each state. It is loaded with N−1 on entry and the state advances when the counter reaches 0.
- **IDLE**
  - `in_ready`=1, `en`=0.
  - `d` keeps the last written word.
  - On `in_valid && in_ready` at an edge: register `in_data` into `d` and go to SETUP.
- **SETUP**: `en`=0 for `SETUP_CYC` cycles.
- **PULSE**: `en`=1 for `PULSE_CYC` cycles. `en` is a registered output, so there are no glitches.
- **HOLD**: `en`=0 for `HOLD_CYC` cycles, then go to IDLE with `done`=1 for one cycle.
- `d` changes only on the accept edge. It is never modified in SETUP, PULSE or HOLD.
- `in_valid` while busy is ignored. The word is not lost at the source because `in_ready`=0.
- `in_data` is sampled only at the accept edge. Later changes have no effect.
- **Reset (async, mid-operation included)**:
  - `en`=0 immediately.
  - `d`=0, state IDLE, counter 0.
  - `done`=0, `busy`=0, `in_ready`=0 while `reset` is low; `in_ready`=1 from the first edge after release.
  - `wr_err`=0 (with `LATCH_WR_READBACK_EN`).

## Timing
- Accept at edge A.
  - Cycles A+1 … A+S are SETUP.
  - Cycles A+S+1 … A+S+P have `en`=1.
  - Cycles A+S+P+1 … A+S+P+H are HOLD.
  - `done`=1 and `in_ready`=1 in cycle A+S+P+H+1.
  - Here S, P, H are `SETUP_CYC`, `PULSE_CYC`, `HOLD_CYC`.
- Back-to-back: a new word may be accepted in the `done` cycle. Write period = S+P+H+1 cycles.
- Counter width is `$clog2(max(S,P,H))`, with a minimum of 1.

## Configuration
- `LATCH_WR_READBACK_EN` defined:
  - Adds `q_rb` and `wr_err`.
  - In the last HOLD cycle, `q_rb` is compared with `d`.
  - On mismatch, `wr_err`=1 in the `done` cycle only.
- Macro undefined: both ports are absent and there is no compare logic. Behaviour is otherwise identical.

## Structure
- Shared package `latch_wr_pkg`:
  - 2-bit state encoding constants (IDLE=0, SETUP=1, PULSE=2, HOLD=3).
  - Counter-width helper function.
- Sub-module `latch_wr_timer`: loadable down-counter with a zero flag, instantiated once.

## Test plan
- **Reset mid-PULSE**: WIDTH=8, S=2, P=3, H=1; drive `reset` low during `en`=1 → `en`, `d`, `busy` and `done` go to 0 with no clock edge; `in_ready`=1 on the first edge after release.
- **Single write**: write 8'hA5 accepted at edge 0 → `en`=1 exactly in cycles 3–5; `d`=8'hA5 from cycle 1; `done` in cycle 7.
- **Back-to-back**: `in_valid` held high with 8'h11 then 8'h22 → second accept in the first write's `done` cycle; `en` pulses 7 cycles apart.
- **Busy ignore**: change `in_data` to 8'hFF and pulse `in_valid` during SETUP → `d` stays 8'hA5 and there is no extra `done`.
- **Minimum timing**: S=P=H=1 → `en` high for exactly 1 cycle; write period 4 cycles.
- **Readback (macro defined)**: `q_rb`=`d` → `wr_err`=0; `q_rb`=8'h00 while `d`=8'h5A → `wr_err`=1 in the `done` cycle only.

Source files
------------

// File: rtl/latch_write_ctrl_pkg.sv
// Shared types and helpers for the latch write sequencer.
// State encoding is fixed: IDLE=0, SETUP=1, PULSE=2, HOLD=3.
package latch_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Width needed to hold max(S,P,H)-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned s,
                                              input int unsigned p,
                                              input int unsigned h);
        int unsigned m;
        m = s;
        if (p > m) m = p;
        if (h > m) m = h;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/latch_write_ctrl_if.sv
// Handshake and latch-side bus of the latch write sequencer.
// LATCH_WR_READBACK_EN adds the q_rb readback and wr_err signals.
interface latch_write_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d;
    logic             en;
    logic             busy;
    logic             done;
`ifdef LATCH_WR_READBACK_EN
    logic [WIDTH-1:0] q_rb;
    logic             wr_err;
`endif

    modport master (
        output in_data, in_valid,
`ifdef LATCH_WR_READBACK_EN
        output q_rb,
        input  wr_err,
`endif
        input  in_ready, d, en, busy, done
    );

    modport slave (
        input  in_data, in_valid,
`ifdef LATCH_WR_READBACK_EN
        input  q_rb,
        output wr_err,
`endif
        output in_ready, d, en, busy, done
    );

endinterface

// File: rtl/latch_write_ctrl_timer.sv
// Loadable down-counter with zero flag; times each sequencer state.
module latch_wr_timer #(
    parameter int unsigned CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [CW-1:0] val_i,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/latch_write_ctrl.sv
// Write sequencer for an enable/reset D-latch bank: setup, enable pulse, hold.
// Optional LATCH_WR_READBACK_EN compares latch readback in the last HOLD cycle.
module latch_write_ctrl
    import latch_wr_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 3,
    parameter int unsigned HOLD_CYC  = 1
) (
    input logic         clk,
    input logic         reset,
    latch_write_ctrl_if.slave bus
);

    localparam int unsigned CW = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic             run_q;
    logic             rdy;
    logic             accept;
    logic             tmr_load;
    logic [CW-1:0]    tmr_val;
    logic             tmr_zero;

    latch_wr_timer #(.CW(CW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .zero_o (tmr_zero)
    );

    // run_q keeps in_ready low until the first edge after reset release.
    assign rdy    = (state_q == ST_IDLE) && run_q;
    assign accept = bus.in_valid && rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            en_q    <= en_d;
            done_q  <= done_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        d_d      = d_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_SETUP;
                    d_d      = bus.in_data;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    state_d  = ST_PULSE;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                end
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (tmr_zero)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // en and done are registered from next-state so the latch sees no glitches.
    always_comb begin
        en_d   = (state_d == ST_PULSE);
        done_d = (state_q == ST_HOLD) && tmr_zero;
    end

    assign bus.in_ready = rdy;
    assign bus.d        = d_q;
    assign bus.en       = en_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;

`ifdef LATCH_WR_READBACK_EN
    logic err_q, err_d;

    assign err_d = done_d && (bus.q_rb != d_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign bus.wr_err = err_q;
`endif

endmodule

// File: tb/tb_latch_write_ctrl.sv
// Scoreboard bench for latch_write_ctrl: nominal (S=2,P=3,H=1) and minimum (1,1,1) instances.
// Readback checks are active when LATCH_WR_READBACK_EN is defined.
module tb_latch_write_ctrl;

    typedef struct {
        logic [7:0] data;
        int         en_start;
        int         en_len;
        int         done_cyc;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    latch_write_ctrl_if #(.WIDTH(8)) ia ();
    latch_write_ctrl_if #(.WIDTH(8)) ib ();

    latch_write_ctrl #(.WIDTH(8), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(1)) dut_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ia)
    );

    latch_write_ctrl #(.WIDTH(8), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dut_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ib)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: tracks en pulses and pops one expectation per done pulse.
    logic ena_prev = 1'b0, enb_prev = 1'b0;
    int   ena_start = 0, ena_len = 0, enb_start = 0, enb_len = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (ia.en && !ena_prev) ena_start = cyc;
            if (!ia.en && ena_prev) ena_len = cyc - ena_start;
            ena_prev = ia.en;
            if (ia.busy && qa.size() > 0) check("a_d_stable", ia.d, qa[0].data);
            if (ia.done) begin
                if (qa.size() == 0) begin
                    check("a_spurious_done", qa.size(), 1);
                end else begin
                    e = qa.pop_front();
                    check("a_d", ia.d, e.data);
                    check("a_en_start", ena_start, e.en_start);
                    check("a_en_len", ena_len, e.en_len);
                    check("a_done_cyc", cyc, e.done_cyc);
`ifdef LATCH_WR_READBACK_EN
                    check("a_wr_err", ia.wr_err, e.err);
`endif
                end
            end
`ifdef LATCH_WR_READBACK_EN
            else check("a_wr_err_idle", ia.wr_err, 0);
`endif

            if (ib.en && !enb_prev) enb_start = cyc;
            if (!ib.en && enb_prev) enb_len = cyc - enb_start;
            enb_prev = ib.en;
            if (ib.busy && qb.size() > 0) check("b_d_stable", ib.d, qb[0].data);
            if (ib.done) begin
                if (qb.size() == 0) begin
                    check("b_spurious_done", qb.size(), 1);
                end else begin
                    e = qb.pop_front();
                    check("b_d", ib.d, e.data);
                    check("b_en_start", enb_start, e.en_start);
                    check("b_en_len", enb_len, e.en_len);
                    check("b_done_cyc", cyc, e.done_cyc);
`ifdef LATCH_WR_READBACK_EN
                    check("b_wr_err", ib.wr_err, e.err);
`endif
                end
            end
        end
    end

    task automatic set_in(input bit sel_b, input logic [7:0] data, input logic v);
        if (sel_b) begin
            ib.in_data  = data;
            ib.in_valid = v;
        end else begin
            ia.in_data  = data;
            ia.in_valid = v;
        end
    endtask

    // Issue one word at a negedge once in_ready is seen; optionally keep
    // in_valid high afterwards or poke a different word during SETUP.
    task automatic wr(input bit sel_b, input logic [7:0] data, input logic [7:0] rb,
                      input bit hold_v, input bit poke);
        int   n;
        int   a;
        int   s, p, h;
        exp_t e;
        s = sel_b ? 1 : 2;
        p = sel_b ? 1 : 3;
        h = 1;
        n = 0;
        while (!(sel_b ? ib.in_ready : ia.in_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(sel_b ? "b_ready_wait" : "a_ready_wait", sel_b ? ib.in_ready : ia.in_ready, 1);
        set_in(sel_b, data, 1'b1);
`ifdef LATCH_WR_READBACK_EN
        if (sel_b) ib.q_rb = rb; else ia.q_rb = rb;
`endif
        a = cyc;
        e.data     = data;
        e.en_start = a + s + 1;
        e.en_len   = p;
        e.done_cyc = a + s + p + h + 1;
        e.err      = (rb != data);
        if (sel_b) qb.push_back(e); else qa.push_back(e);
        @(negedge clk);
        if (!hold_v) set_in(sel_b, data, 1'b0);
        if (poke) begin
            set_in(sel_b, 8'hFF, 1'b1);
            @(negedge clk);
            set_in(sel_b, 8'hFF, 1'b0);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_a_en"}, ia.en, 0);
        check({tag, "_a_d"}, ia.d, 0);
        check({tag, "_a_busy"}, ia.busy, 0);
        check({tag, "_a_done"}, ia.done, 0);
        check({tag, "_a_rdy"}, ia.in_ready, 0);
        check({tag, "_b_en"}, ib.en, 0);
        check({tag, "_b_rdy"}, ib.in_ready, 0);
`ifdef LATCH_WR_READBACK_EN
        check({tag, "_a_wr_err"}, ia.wr_err, 0);
`endif
    endtask

    initial begin
        int n;
        set_in(1'b0, 8'h00, 1'b0);
        set_in(1'b1, 8'h00, 1'b0);
`ifdef LATCH_WR_READBACK_EN
        ia.q_rb = 8'h00;
        ib.q_rb = 8'h00;
`endif
        repeat (2) @(negedge clk);
        check_reset_outs("rst");
        rst_n = 1'b1;
        #1 check("rel_a_rdy_pre_edge", ia.in_ready, 0);
        @(posedge clk);
        #1 check("rel_a_rdy", ia.in_ready, 1);
        check("rel_b_rdy", ib.in_ready, 1);
        @(negedge clk);

        wr(1'b0, 8'hA5, 8'hA5, 1'b0, 1'b1);
        wr(1'b0, 8'h11, 8'h11, 1'b1, 1'b0);
        wr(1'b0, 8'h22, 8'h22, 1'b0, 1'b0);
        wr(1'b1, 8'h33, 8'h33, 1'b1, 1'b0);
        wr(1'b1, 8'h44, 8'h44, 1'b0, 1'b0);
        wr(1'b0, 8'h5A, 8'h5A, 1'b0, 1'b0);
        wr(1'b0, 8'h5A, 8'h00, 1'b0, 1'b0);

        // Abort a write with asynchronous reset while en is high.
        wr(1'b0, 8'hC3, 8'hC3, 1'b0, 1'b0);
        n = 0;
        while ((!ia.en || qb.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("a_en_before_reset", ia.en, 1);
        #2 rst_n = 1'b0;
        qa.delete();
        qb.delete();
        #1 check_reset_outs("mid");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel2_a_rdy_pre_edge", ia.in_ready, 0);
        @(posedge clk);
        #1 check("rel2_a_rdy", ia.in_ready, 1);
        @(negedge clk);

        wr(1'b0, 8'h96, 8'h96, 1'b0, 1'b0);
        wr(1'b1, 8'h69, 8'h69, 1'b0, 1'b0);

        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("queues_drained", qa.size() + qb.size(), 0);
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
